// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and lane helpers for the MEM stage.
package mem_access_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = 8;

  // Access size encodings from EX/MEM (2'b11 behaves as word)
  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_BUSY = 2'b01,
    MS_DONE = 2'b10
  } ms_state_e;

  // Halfwords must be 2-byte aligned, words 4-byte aligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: return 1'b0;
      MEM_SIZE_H: return off[0];
      default:    return (off != 2'b00);
    endcase
  endfunction

  // Little-endian byte enables for the addressed lanes
  function automatic logic [BE_W-1:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      MEM_SIZE_B: return BE_W'(4'b0001 << off);
      MEM_SIZE_H: return off[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

  // Replicate narrow store data so every candidate lane carries it
  function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] rt);
    case (size)
      MEM_SIZE_B: return {4{rt[7:0]}};
      MEM_SIZE_H: return {2{rt[15:0]}};
      default:    return rt;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: word-aligned request with req/ready handshake.
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic            dm_req;
  logic            dm_we;
  logic [XLEN-1:0] dm_addr;
  logic [BE_W-1:0] dm_be;
  logic [XLEN-1:0] dm_wdata;
  logic [XLEN-1:0] dm_rdata;
  logic            dm_ready;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_rdata, dm_ready
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_rdata, dm_ready
  );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Selects the addressed byte/halfword of a read word and extends it.
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [1:0]      size_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select followed by sign/zero extension
  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    case (size_i)
      MEM_SIZE_B: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      MEM_SIZE_H: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default:    data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX/MEM load/store control into a bus transaction,
// stalls the pipeline while it is outstanding, returns aligned load data.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_mem_mem_r,
  input  logic                ex_mem_mem_w,
  input  logic [1:0]          ex_mem_mem_size,
  input  logic                ex_mem_mem_signed,
  input  logic [XLEN-1:0]     ex_mem_alu_result,
  input  logic [XLEN-1:0]     ex_mem_rt_data,
  mem_access_stage_if.master  dm_bus,
  output logic [XLEN-1:0]     dm_r_data,
  output logic                mem_stall,
  output logic                mem_misalign,
  output logic                mem_bus_err
);

  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W+1)'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ms_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  hold_q, hold_d;

  logic            access;
  logic [1:0]      off;
  logic            misalign;
  logic            timeout;
  logic            req;
  logic [XLEN-1:0] load_data;

  assign access   = ex_mem_mem_r | ex_mem_mem_w;
  assign off      = ex_mem_alu_result[1:0];
  assign misalign = is_misaligned(ex_mem_mem_size, off);
  assign timeout  = ({1'b0, cnt_q} + (CNT_W+1)'(1)) >= TO_LIMIT;

  mem_load_align u_align (
    .rdata_i  (dm_bus.dm_rdata),
    .off_i    (off),
    .size_i   (ex_mem_mem_size),
    .signed_i (ex_mem_mem_signed),
    .data_o   (load_data)
  );

  // Bus fields come straight from the frozen EX/MEM inputs
  assign dm_bus.dm_req   = req;
  assign dm_bus.dm_we    = req & ex_mem_mem_w;
  assign dm_bus.dm_addr  = {ex_mem_alu_result[XLEN-1:2], 2'b00};
  assign dm_bus.dm_be    = req ? byte_enables(ex_mem_mem_size, off) : '0;
  assign dm_bus.dm_wdata = store_lanes(ex_mem_mem_size, ex_mem_rt_data);

  // State, timeout counter and load hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next state and handshake/stall outputs; reset forces outputs quiet
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    req          = 1'b0;
    mem_stall    = 1'b0;
    mem_misalign = 1'b0;
    mem_bus_err  = 1'b0;
    dm_r_data    = hold_q;
    case (state_q)
      MS_IDLE: begin
        if (access) begin
          if (misalign) begin
            mem_misalign = 1'b1;
            dm_r_data    = '0;
          end else begin
            req       = 1'b1;
            mem_stall = 1'b1;
            cnt_d     = '0;
            state_d   = MS_BUSY;
          end
        end
      end
      MS_BUSY: begin
        req       = 1'b1;
        mem_stall = 1'b1;
        if (dm_bus.dm_ready) begin
          hold_d  = ex_mem_mem_r ? load_data : '0;
          state_d = MS_DONE;
        end else if (timeout) begin
          mem_bus_err = 1'b1;
          hold_d      = '0;
          state_d     = MS_DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MS_DONE: state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
    if (reset) begin
      req          = 1'b0;
      mem_stall    = 1'b0;
      mem_misalign = 1'b0;
      mem_bus_err  = 1'b0;
      dm_r_data    = '0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_r, mem_w, mem_signed;
  logic [1:0]  mem_size;
  logic [31:0] alu_result, rt_data;
  logic [31:0] dm_r_data;
  logic        mem_stall, mem_misalign, mem_bus_err;

  int n_total = 0;
  int n_bad   = 0;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_mem_mem_r      (mem_r),
    .ex_mem_mem_w      (mem_w),
    .ex_mem_mem_size   (mem_size),
    .ex_mem_mem_signed (mem_signed),
    .ex_mem_alu_result (alu_result),
    .ex_mem_rt_data    (rt_data),
    .dm_bus            (bus),
    .dm_r_data         (dm_r_data),
    .mem_stall         (mem_stall),
    .mem_misalign      (mem_misalign),
    .mem_bus_err       (mem_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic no_access();
    mem_r = 1'b0;
    mem_w = 1'b0;
  endtask

  // Load with ready during the first BUSY cycle, checked through DONE
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    mem_r = 1'b1; mem_w = 1'b0; mem_size = size; mem_signed = sgn; alu_result = addr;
    bus.dm_ready = 1'b0;
    settle();
    chk({tag, "_req"},   32'(bus.dm_req), 32'd1);
    chk({tag, "_stall0"}, 32'(mem_stall), 32'd1);
    chk({tag, "_be"},    32'(bus.dm_be), 32'(exp_be));
    chk({tag, "_addr"},  bus.dm_addr, {addr[31:2], 2'b00});
    chk({tag, "_we"},    32'(bus.dm_we), 32'd0);
    tick();
    bus.dm_ready = 1'b1; bus.dm_rdata = rdata;
    settle();
    chk({tag, "_stall1"}, 32'(mem_stall), 32'd1);
    tick();
    bus.dm_ready = 1'b0;
    settle();
    chk({tag, "_done_req"},   32'(bus.dm_req), 32'd0);
    chk({tag, "_done_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, "_data"},       dm_r_data, exp_data);
    tick();
    no_access();
  endtask

  initial begin
    reset = 1'b1; mem_r = 1'b0; mem_w = 1'b0; mem_signed = 1'b0;
    mem_size = MEM_SIZE_W; alu_result = '0; rt_data = '0;
    bus.dm_rdata = '0; bus.dm_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_req",  32'(bus.dm_req), 32'd0);
    chk("rst_we",   32'(bus.dm_we), 32'd0);
    chk("rst_be",   32'(bus.dm_be), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_mis",  32'(mem_misalign), 32'd0);
    chk("rst_err",  32'(mem_bus_err), 32'd0);
    chk("rst_data", dm_r_data, 32'd0);
    tick();

    do_load("lb_s",  32'h0000_1003, MEM_SIZE_B, 1'b1, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
    do_load("lhu",   32'h0000_2002, MEM_SIZE_H, 1'b0, 32'hBEEF_0000, 4'b1100, 32'h0000_BEEF);
    do_load("lh_s",  32'h0000_2002, MEM_SIZE_H, 1'b1, 32'hBEEF_0000, 4'b1100, 32'hFFFF_BEEF);
    do_load("lbu1",  32'h0000_3001, MEM_SIZE_B, 1'b0, 32'h1122_C344, 4'b0010, 32'h0000_00C3);

    // sb with ready arriving in the third BUSY cycle
    mem_w = 1'b1; mem_r = 1'b0; mem_size = MEM_SIZE_B; alu_result = 32'h0000_0001;
    rt_data = 32'h1234_56AB;
    settle();
    chk("sb_we",    32'(bus.dm_we), 32'd1);
    chk("sb_be",    32'(bus.dm_be), 32'h2);
    chk("sb_wdata", bus.dm_wdata, 32'hABAB_ABAB);
    chk("sb_addr",  bus.dm_addr, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.dm_ready = (i == 2);
      settle();
      chk("sb_hold_req",   32'(bus.dm_req), 32'd1);
      chk("sb_hold_be",    32'(bus.dm_be), 32'h2);
      chk("sb_hold_wdata", bus.dm_wdata, 32'hABAB_ABAB);
      chk("sb_hold_stall", 32'(mem_stall), 32'd1);
      tick();
    end
    bus.dm_ready = 1'b0;
    settle();
    chk("sb_done_req",   32'(bus.dm_req), 32'd0);
    chk("sb_done_stall", 32'(mem_stall), 32'd0);
    tick();
    no_access();

    // Misaligned lw: no request, single misalign pulse
    mem_r = 1'b1; mem_size = MEM_SIZE_W; alu_result = 32'h0000_0006;
    settle();
    chk("mis_req",   32'(bus.dm_req), 32'd0);
    chk("mis_flag",  32'(mem_misalign), 32'd1);
    chk("mis_stall", 32'(mem_stall), 32'd0);
    chk("mis_data",  dm_r_data, 32'd0);
    tick();
    no_access();
    settle();
    chk("mis_pulse", 32'(mem_misalign), 32'd0);
    tick();

    // Misaligned lh at odd address
    mem_r = 1'b1; mem_size = MEM_SIZE_H; alu_result = 32'h0000_0103;
    settle();
    chk("mis_h_flag", 32'(mem_misalign), 32'd1);
    chk("mis_h_req",  32'(bus.dm_req), 32'd0);
    tick();
    no_access();

    // Prime hold register, then time out: bus error on 4th BUSY cycle
    do_load("pre_to", 32'h0000_0040, MEM_SIZE_W, 1'b0, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    mem_r = 1'b1; mem_size = MEM_SIZE_W; alu_result = 32'h0000_0008;
    settle();
    chk("to_req", 32'(bus.dm_req), 32'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("to_busy_stall", 32'(mem_stall), 32'd1);
      chk("to_err",        32'(mem_bus_err), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end
    settle();
    chk("to_done_err",   32'(mem_bus_err), 32'd0);
    chk("to_done_data",  dm_r_data, 32'd0);
    chk("to_done_stall", 32'(mem_stall), 32'd0);
    chk("to_done_req",   32'(bus.dm_req), 32'd0);
    tick();
    no_access();
    settle();
    chk("to_idle_req", 32'(bus.dm_req), 32'd0);
    tick();

    // Reset while BUSY, then a normal sw
    mem_r = 1'b1; mem_size = MEM_SIZE_W; alu_result = 32'h0000_0020;
    tick();
    settle();
    chk("rb_busy_req", 32'(bus.dm_req), 32'd1);
    reset = 1'b1;
    no_access();
    tick();
    reset = 1'b0;
    settle();
    chk("rb_req",   32'(bus.dm_req), 32'd0);
    chk("rb_stall", 32'(mem_stall), 32'd0);
    mem_w = 1'b1; mem_size = MEM_SIZE_W; alu_result = 32'h0000_0010; rt_data = 32'hCAFE_F00D;
    settle();
    chk("sw_req",   32'(bus.dm_req), 32'd1);
    chk("sw_we",    32'(bus.dm_we), 32'd1);
    chk("sw_be",    32'(bus.dm_be), 32'hF);
    chk("sw_addr",  bus.dm_addr, 32'h10);
    chk("sw_wdata", bus.dm_wdata, 32'hCAFE_F00D);
    tick();
    bus.dm_ready = 1'b1;
    settle();
    chk("sw_busy_stall", 32'(mem_stall), 32'd1);
    tick();
    bus.dm_ready = 1'b0;
    settle();
    chk("sw_done_stall", 32'(mem_stall), 32'd0);
    chk("sw_done_req",   32'(bus.dm_req), 32'd0);
    tick();
    no_access();
    settle();
    chk("sw_idle_req", 32'(bus.dm_req), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
